// File: rtl/spad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spad_pkg
// Description : Shared constants and types for the scratchpad burst master.
//               Holds the default geometry (address width, data width,
//               scratchpad depth) and the burst FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package spad_pkg;

  localparam int C_ADDR_W     = 4;   // scratchpad address width
  localparam int C_DATA_WIDTH = 16;  // data word width
  localparam int C_SPADSIZE   = 12;  // number of scratchpad words

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } spad_state_t;

endpackage : spad_pkg
`default_nettype wire

// File: rtl/spad_rd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spad_rd_fifo
// Description : Two-entry read-data FIFO between the scratchpad read port and
//               the rd_* output stream. A push and a pop in the same cycle
//               leave the occupancy unchanged.
// Ports       : clk, rst_n          - clock, async active-low reset
//               push_i/push_data_i - write side (word from scratchpad)
//               pop_i              - consumer ready; pops only when non-empty
//               valid_o/data_o     - head of FIFO
//               count_o            - occupancy 0..2 (used for read credits)
// Revision    : 1.0 - initial release
// ============================================================================
module spad_rd_fifo #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            count_o
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [1:0]            count_q, count_d;
  logic                  do_push;
  logic                  do_pop;

  // Pop is gated by occupancy; push is accepted when there is room or when
  // the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop_i && (count_q != 2'd0);
    do_push = push_i && ((count_q != 2'd2) || do_pop);
    head_d  = do_pop  ? ~head_q : head_q;
    tail_d  = do_push ? ~tail_q : tail_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed when count_q says so.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[tail_q] <= push_data_i;
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign data_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule : spad_rd_fifo
`default_nettype wire

// File: rtl/spad_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : spad_burst_master
// Description : Burst read/write master for a single-port scratchpad with a
//               registered (1-cycle) read. Writes stream straight through
//               from wr_*; reads are credit-limited so that at most two words
//               are ever buffered or in flight, feeding a 2-entry FIFO.
// Ports       : clk, rst_n              - clock, async active-low reset
//               cmd_*_i / cmd_ready_o   - burst command (write, addr, len)
//               wr_*                    - write-data stream in
//               rd_*                    - read-data stream out
//               spad_*                  - scratchpad port (we=0 is a read)
//               busy_o/done_o/err_o     - status; done/err are pulses
// Revision    : 1.0 - initial release
// ============================================================================
module spad_burst_master
  import spad_pkg::*;
#(
  parameter int ADDR       = C_ADDR_W,
  parameter int DATA_WIDTH = C_DATA_WIDTH,
  parameter int SPADSIZE   = C_SPADSIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR-1:0]       cmd_addr_i,
  input  logic [ADDR:0]         cmd_len_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [ADDR-1:0]       spad_addr_o,
  output logic                  spad_we_o,
  output logic [DATA_WIDTH-1:0] spad_wdata_o,
  input  logic [DATA_WIDTH-1:0] spad_rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  // Compare in ADDR+1 bits so SPADSIZE == 2**ADDR still works.
  localparam logic [ADDR:0]   C_SIZE_EXT  = (ADDR+1)'(SPADSIZE);
  localparam logic [ADDR-1:0] C_LAST_ADDR = ADDR'(SPADSIZE - 1);

  spad_state_t           state_q, state_d;
  logic [ADDR-1:0]       ptr_q, ptr_d;
  logic [ADDR:0]         cnt_q, cnt_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            fifo_count;
  logic [2:0]            credit;
  logic                  rd_hs;
  logic                  issue_ok;
  logic                  cmd_bad;
  logic [ADDR-1:0]       ptr_next;

  assign rd_hs    = rd_valid_o && rd_ready_i;
  assign credit   = {1'b0, fifo_count} + {2'b00, inflight_q};
  // A read may be issued when fewer than two words are owed to the FIFO, or
  // when exactly two are owed but the head leaves this cycle.
  assign issue_ok = (credit < 3'd2) || ((credit == 3'd2) && rd_hs);
  assign cmd_bad  = (cmd_len_i == '0) || (cmd_len_i > C_SIZE_EXT) ||
                    ({1'b0, cmd_addr_i} >= C_SIZE_EXT);
  assign ptr_next = (ptr_q == C_LAST_ADDR) ? '0 : ptr_q + ADDR'(1);

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    inflight_d   = 1'b0;
    cmd_ready_o  = 1'b0;
    wr_ready_o   = 1'b0;
    spad_we_o    = 1'b0;
    spad_addr_o  = '0;
    spad_wdata_o = '0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    err_o        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_o      = 1'b0;
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          if (cmd_bad) begin
            err_o = 1'b1;
          end else begin
            ptr_d   = cmd_addr_i;
            cnt_d   = cmd_len_i;
            state_d = cmd_write_i ? ST_WRITE : ST_READ;
          end
        end
      end

      ST_WRITE: begin
        wr_ready_o   = 1'b1;
        spad_addr_o  = ptr_q;
        spad_we_o    = wr_valid_i;
        spad_wdata_o = wr_data_i;
        if (wr_valid_i) begin
          ptr_d = ptr_next;
          cnt_d = cnt_q - (ADDR+1)'(1);
          if (cnt_q == (ADDR+1)'(1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_READ: begin
        spad_addr_o = ptr_q;
        if ((cnt_q != '0) && issue_ok) begin
          inflight_d = 1'b1;
          ptr_d      = ptr_next;
          cnt_d      = cnt_q - (ADDR+1)'(1);
          if (cnt_q == (ADDR+1)'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (!inflight_q && !rd_valid_o) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
    end
  end

  // The word addressed in the previous cycle arrives now on spad_rdata_i.
  spad_rd_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rd_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (spad_rdata_i),
    .pop_i       (rd_ready_i),
    .valid_o     (rd_valid_o),
    .data_o      (rd_data_o),
    .count_o     (fifo_count)
  );

endmodule : spad_burst_master
`default_nettype wire

// File: tb/tb_spad_burst_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spad_burst_master
// Description : Scoreboard bench for spad_burst_master. Stimulus pushes the
//               expected scratchpad writes and read words into queues; a
//               negedge monitor pops and compares whenever the DUT writes the
//               scratchpad or completes a rd handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spad_burst_master;

  localparam int ADDR     = 4;
  localparam int DW       = 16;
  localparam int SPADSIZE = 12;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_valid, cmd_ready, cmd_write;
  logic [ADDR-1:0] cmd_addr;
  logic [ADDR:0]   cmd_len;
  logic            wr_valid, wr_ready;
  logic [DW-1:0]   wr_data;
  logic            rd_valid, rd_ready;
  logic [DW-1:0]   rd_data;
  logic [ADDR-1:0] spad_addr;
  logic            spad_we;
  logic [DW-1:0]   spad_wdata, spad_rdata;
  logic            busy, done, err;

  // Scratchpad model with a side-port for preloading.
  logic [DW-1:0]   mem [16];
  logic            pre_we;
  logic [ADDR-1:0] pre_addr;
  logic [DW-1:0]   pre_data;

  typedef struct packed {
    logic [ADDR-1:0] addr;
    logic [DW-1:0]   data;
  } wr_exp_t;

  wr_exp_t       exp_wr [$];
  logic [DW-1:0] exp_rd [$];
  wr_exp_t       mon_e;
  logic [DW-1:0] mon_d;

  int checks     = 0;
  int failures   = 0;
  int done_seen  = 0;
  int err_seen   = 0;

  always #5 clk = ~clk;

  spad_burst_master #(
    .ADDR       (ADDR),
    .DATA_WIDTH (DW),
    .SPADSIZE   (SPADSIZE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_write_i  (cmd_write),
    .cmd_addr_i   (cmd_addr),
    .cmd_len_i    (cmd_len),
    .wr_valid_i   (wr_valid),
    .wr_ready_o   (wr_ready),
    .wr_data_i    (wr_data),
    .rd_valid_o   (rd_valid),
    .rd_ready_i   (rd_ready),
    .rd_data_o    (rd_data),
    .spad_addr_o  (spad_addr),
    .spad_we_o    (spad_we),
    .spad_wdata_o (spad_wdata),
    .spad_rdata_i (spad_rdata),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err)
  );

  always @(posedge clk) begin
    if (pre_we)       mem[pre_addr]  <= pre_data;
    else if (spad_we) mem[spad_addr] <= spad_wdata;
    spad_rdata <= mem[spad_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (spad_we) begin
        if (exp_wr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=addr %0d data 0x%0h required=no write", spad_addr, spad_wdata);
        end else begin
          mon_e = exp_wr.pop_front();
          check("wr_addr", 32'(spad_addr), 32'(mon_e.addr));
          check("wr_data", 32'(spad_wdata), 32'(mon_e.data));
        end
      end
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rd actual=0x%0h required=no word", rd_data);
        end else begin
          mon_d = exp_rd.pop_front();
          check("rd_data", 32'(rd_data), 32'(mon_d));
        end
      end
      if (done) done_seen++;
      if (err)  err_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command for one cycle; returns 1 time unit after the handshake edge.
  task automatic send_cmd(input logic w, input logic [ADDR-1:0] a, input logic [ADDR:0] l);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [ADDR-1:0] rd_addrs [4];
    logic [ADDR-1:0] pl_addr  [4];
    logic [DW-1:0]   pl_data  [4];
    logic            tog      [5];

    rd_addrs = '{4'd10, 4'd11, 4'd0, 4'd1};
    pl_addr  = '{4'd10, 4'd11, 4'd0, 4'd1};
    pl_data  = '{16'h1010, 16'h1111, 16'h1000, 16'h1001};
    tog      = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    // Reset values
    #12;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_rd_valid",  32'(rd_valid),  32'd0);
    check("rst_wr_ready",  32'(wr_ready),  32'd0);
    check("rst_spad_we",   32'(spad_we),   32'd0);
    check("rst_spad_addr", 32'(spad_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Write addr=2 len=4, wr_valid held
    send_cmd(1'b1, 4'd2, 5'd4);
    for (int i = 0; i < 4; i++) begin
      exp_wr.push_back('{addr: ADDR'(2 + i), data: DW'(16'hA0 + i)});
    end
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = DW'(16'hA0 + i);
      if (i == 0) check("wr_ready_in_write", 32'(wr_ready), 32'd1);
      tick();
    end
    wr_valid = 1'b0;
    check("wr_done_pulse", 32'(done), 32'd1);
    wait_idle("wr_idle");
    check("wr_ready_idle", 32'(wr_ready), 32'd0);

    // Preload and read addr=10 len=4 with wrap
    pre_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pre_addr = pl_addr[i];
      pre_data = pl_data[i];
      tick();
    end
    pre_we = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_rd.push_back(pl_data[i]);
    send_cmd(1'b0, 4'd10, 5'd4);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("rd_addr_c%0d", k), 32'(spad_addr), 32'(rd_addrs[k-1]));
      check($sformatf("rd_we_c%0d", k), 32'(spad_we), 32'd0);
      if (k == 2) check("rd_valid_early", 32'(rd_valid), 32'd0);
      if (k == 3) check("rd_valid_first", 32'(rd_valid), 32'd1);
    end
    tick();
    wait_idle("rd_idle");

    // Read addr=0 len=6 with back-pressure for 5 cycles
    rd_ready = 1'b0;
    exp_rd.push_back(16'h1000); exp_rd.push_back(16'h1001);
    exp_rd.push_back(16'h00A0); exp_rd.push_back(16'h00A1);
    exp_rd.push_back(16'h00A2); exp_rd.push_back(16'h00A3);
    send_cmd(1'b0, 4'd0, 5'd6);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) check("bp_addr_c1", 32'(spad_addr), 32'd0);
      if (k == 2) check("bp_addr_c2", 32'(spad_addr), 32'd1);
      if (k >= 3) check($sformatf("bp_stall_c%0d", k), 32'(spad_addr), 32'd2);
    end
    check("bp_rd_valid", 32'(rd_valid), 32'd1);
    @(posedge clk);
    #1;
    rd_ready = 1'b1;
    wait_idle("bp_idle");

    // Illegal commands
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = (i == 2) ? 4'd12 : 4'd0;
      cmd_len   = (i == 0) ? 5'd0 : ((i == 1) ? 5'd13 : 5'd4);
      @(negedge clk);
      check($sformatf("ill%0d_err", i), 32'(err), 32'd1);
      check($sformatf("ill%0d_busy", i), 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      check($sformatf("ill%0d_err_off", i), 32'(err), 32'd0);
      check($sformatf("ill%0d_busy_after", i), 32'(busy), 32'd0);
      tick();
    end

    // Reset in cycle 2 of a len=8 write, then a read right after release
    exp_wr.push_back('{addr: 4'd0, data: 16'h00B0});
    send_cmd(1'b1, 4'd0, 5'd8);
    wr_valid = 1'b1;
    wr_data  = 16'h00B0;
    tick();
    wr_data  = 16'h00B1;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("arst_busy",      32'(busy),      32'd0);
    check("arst_done",      32'(done),      32'd0);
    check("arst_err",       32'(err),       32'd0);
    check("arst_rd_valid",  32'(rd_valid),  32'd0);
    check("arst_wr_ready",  32'(wr_ready),  32'd0);
    check("arst_spad_we",   32'(spad_we),   32'd0);
    check("arst_spad_addr", 32'(spad_addr), 32'd0);
    wr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    rd_ready  = 1'b1;
    exp_rd.push_back(16'h00B0);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 4'd0;
    cmd_len   = 5'd1;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("post_rst_busy", 32'(busy), 32'd1);
    wait_idle("post_rst_idle");

    // Write len=3 with wr_valid toggling 1,0,1,0,1
    exp_wr.push_back('{addr: 4'd7, data: 16'h00C0});
    exp_wr.push_back('{addr: 4'd8, data: 16'h00C1});
    exp_wr.push_back('{addr: 4'd9, data: 16'h00C2});
    send_cmd(1'b1, 4'd7, 5'd3);
    for (int k = 0; k < 5; k++) begin
      wr_valid = tog[k];
      wr_data  = DW'(16'hC0 + k / 2);
      @(negedge clk);
      if (!tog[k]) begin
        check($sformatf("gap%0d_we", k), 32'(spad_we), 32'd0);
        check($sformatf("gap%0d_addr", k), 32'(spad_addr), (k == 1) ? 32'd8 : 32'd9);
      end
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    wait_idle("tog_idle");

    tick();
    tick();
    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    check("done_count",     32'(done_seen),     32'd5);
    check("err_count",      32'(err_seen),      32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_spad_burst_master
`default_nettype wire

// File: doc/spad_burst_master.md
SPAD_BURST_MASTER -- requirements
Module: spad_burst_master

Interface
REQ-001 Parameter ADDR, default 4: scratchpad address width.
REQ-002 Parameter DATA_WIDTH, default 16: data word width.
REQ-003 Parameter SPADSIZE, default 12: number of scratchpad words; legal addresses are 0..SPADSIZE-1.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; transfer occurs when both are high.
REQ-007 cmd_write  in  1  1 = burst write to the scratchpad, 0 = burst read from it.
REQ-008 cmd_addr  in  ADDR  burst start address.
REQ-009 cmd_len  in  ADDR+1  burst length in words; legal range is 1..SPADSIZE.
REQ-010 wr_valid / wr_ready / wr_data  in / out / in  1 / 1 / DATA_WIDTH  write-data stream into the block.
REQ-011 rd_valid / rd_ready / rd_data  out / in / out  1 / 1 / DATA_WIDTH  read-data stream out of the block.
REQ-012 spad_addr / spad_we / spad_wdata  out  ADDR / 1 / DATA_WIDTH  scratchpad port; spad_we=0 means a read.
REQ-013 spad_rdata  in  DATA_WIDTH  scratchpad registered read data, valid one cycle after the read address is presented with spad_we=0.
REQ-014 busy / done / err  out  1 / 1 / 1  busy is high outside IDLE; done and err are single-cycle pulses.

Function
REQ-015 FSM states: IDLE, WRITE, READ, DRAIN, DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-016 IDLE: on a cmd handshake with cmd_len=0, cmd_len>SPADSIZE, or cmd_addr>=SPADSIZE, the block SHALL pulse err for one cycle and remain in IDLE.
REQ-017 IDLE: on a legal cmd handshake, the block SHALL load the address pointer with cmd_addr and the remaining count with cmd_len, then enter WRITE (cmd_write=1) or READ (cmd_write=0).
REQ-018 Address pointer increments by 1 per issued access and SHALL wrap from SPADSIZE-1 to 0.
REQ-019 WRITE: wr_ready=1; spad_we = wr_valid (combinational); spad_wdata = wr_data; spad_addr = pointer; each wr handshake consumes one word.
REQ-020 WRITE: the handshake of the last word SHALL move the FSM to DONE.
REQ-021 READ: a read is issued (spad_we=0, spad_addr=pointer) in a cycle only if fifo_count + inflight < 2, or if that sum equals 2 and rd_valid&&rd_ready holds in the same cycle.
REQ-022 The inflight flag SHALL be set on an issue cycle; in the following cycle spad_rdata SHALL be pushed into a 2-entry read FIFO.
REQ-023 rd_valid = FIFO not empty; rd_data = FIFO head; rd_handshake pops the head; a simultaneous push and pop SHALL keep the count unchanged.
REQ-024 With rd_ready held high, the read path SHALL sustain one word per cycle; the first rd_valid SHALL occur 3 cycles after the cmd handshake cycle.
REQ-025 After the last read is issued, the FSM SHALL go to DRAIN; DRAIN -> DONE once inflight=0 and the FIFO is empty.
REQ-026 DONE: done=1 for exactly one cycle, then IDLE.
REQ-027 Outside WRITE/READ: spad_we=0, spad_addr=0, wr_ready=0; no scratchpad access is counted.
REQ-028 Commands SHALL NOT be aborted; cmd_valid is ignored while busy.

Reset
REQ-029 Asserting rst_n=0 at any time, including mid-burst, SHALL immediately force: FSM=IDLE, pointer=0, count=0, inflight=0, FIFO empty, cmd_ready=1, busy=0, done=0, err=0, rd_valid=0, wr_ready=0, spad_we=0, spad_addr=0.
REQ-030 Data words lost by reset SHALL NOT be replayed; the first cycle after deassertion SHALL accept a command.

Structure
REQ-031 Package spad_pkg SHALL hold the default ADDR/DATA_WIDTH/SPADSIZE constants and the FSM state enum typedef.
REQ-032 The 2-entry read FIFO SHALL be a sub-module named spad_rd_fifo; the FSM, pointer and credit logic SHALL live in spad_burst_master.

Verification
REQ-033 Write addr=2, len=4, data 0xA0..0xA3 with wr_valid held -> spad_we on 4 consecutive cycles at addrs 2,3,4,5; done pulses once.
REQ-034 Read addr=10, len=4 with memory preloaded, rd_ready=1 -> spad_addr sequence 10,11,0,1; rd_data matches in order; first rd_valid 3 cycles after the cmd handshake.
REQ-035 Read len=6 with rd_ready low for 5 cycles, then high -> exactly 2 words are buffered, no read is issued while full, and no data is lost or duplicated.
REQ-036 Commands with len=0, len=13, and addr=12 -> err pulses for each, busy stays 0, and there is no scratchpad access.
REQ-037 rst_n low in cycle 2 of a len=8 write -> all outputs are at reset values asynchronously; a new read command is accepted right after release.
REQ-038 Write len=3 with wr_valid toggling 1,0,1,0,1 -> exactly 3 writes, spad_we=0 in the gap cycles, and the pointer is unchanged across the gaps.
